// File: rtl/function_code_encoder_pkg.sv
// rtl/function_code_encoder_pkg.sv - shared types and constants for the function code encoder
//
// Purpose: FSM state encoding and code constants shared by the encoder and
//          the display-side path.
// Ports:   none (package).
package function_code_encoder_pkg;

  localparam int SW_W   = 7;
  localparam int CODE_W = 3;

  // The display path accepts only function 2; every other code is still
  // produced by the encoder.
  localparam logic [CODE_W-1:0] FUNC_CODE_DISPLAYABLE = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_RELEASE  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/function_code_encoder_onehot_to_code.sv
// rtl/function_code_encoder_onehot_to_code.sv - one-hot switch selection to 3-bit function code
//
// Purpose: combinational encoder; switch bit k set alone gives code k+1.
// Ports:
//   sel   in   7  switch vector, sel[n-1] selects function n
//   code  out  3  function code, 000 when the selection is not legal
//   legal out  1  exactly one switch is set
module onehot_to_code
  import function_code_encoder_pkg::*;
(
  input  logic [SW_W-1:0]   sel,
  output logic [CODE_W-1:0] code,
  output logic              legal
);

  logic [3:0]        ones;
  logic [CODE_W-1:0] idx_code;

  always_comb begin
    ones     = '0;
    idx_code = '0;
    for (int i = 0; i < SW_W; i++) begin
      if (sel[i]) begin
        ones     = ones + 4'd1;
        idx_code = CODE_W'(i + 1);
      end
    end
    legal = (ones == 4'd1);
    code  = legal ? idx_code : '0;
  end

endmodule

// File: rtl/function_code_encoder.sv
// rtl/function_code_encoder.sv - debounced confirm button commits a one-hot switch selection as a 3-bit code
//
// Purpose: synchronises and debounces the confirm button, samples the
//          function switches once per accepted press and holds the code.
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous active-high reset
//   sw           in   7  function switches, sw[n-1] selects function n
//   btn          in   1  raw bouncy confirm button, active-high
//   clr          in   1  drop the held code
//   A, B, C      out  1  held code, A is the MSB
//   code_valid   out  1  held code is a legal committed selection
//   commit_pulse out  1  one-cycle strobe, legal code committed
//   err_pulse    out  1  one-cycle strobe, zero or several switches set
module function_code_encoder
  import function_code_encoder_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw,
  input  logic            btn,
  input  logic            clr,
  output logic            A,
  output logic            B,
  output logic            C,
  output logic            code_valid,
  output logic            commit_pulse,
  output logic            err_pulse
);

  localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic              btn_m;
  logic              btn_s;
  fsm_state_t        state;
  fsm_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CODE_W-1:0] sel_code;
  logic              sel_legal;
  logic [CODE_W-1:0] code_q;

  onehot_to_code u_onehot_to_code (
    .sel   (sw),
    .code  (sel_code),
    .legal (sel_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The IDLE sample counts as the first of the DEB_CYCLES high samples, so
  // the count starts at 1 on entry to DEBOUNCE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (btn_s) begin
          state_nxt = ST_DEBOUNCE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!btn_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_COMMIT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        state_nxt = ST_RELEASE;
        cnt_nxt   = '0;
      end
      ST_RELEASE: begin
        // Any high sample restarts the release count, so a held or bouncing
        // button cannot reach IDLE and cannot commit twice.
        if (btn_s) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The commit update takes priority over clr when both land on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q       <= '0;
      code_valid   <= 1'b0;
      commit_pulse <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      err_pulse    <= 1'b0;
      if (state == ST_COMMIT) begin
        code_q       <= sel_code;
        code_valid   <= sel_legal;
        commit_pulse <= sel_legal;
        err_pulse    <= ~sel_legal;
      end else if (clr) begin
        code_q     <= '0;
        code_valid <= 1'b0;
      end
    end
  end

  assign A = code_q[2];
  assign B = code_q[1];
  assign C = code_q[0];

endmodule

// File: tb/tb_function_code_encoder.sv
// tb/tb_function_code_encoder.sv - scoreboard bench for function_code_encoder
module tb_function_code_encoder;
  import function_code_encoder_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] sw;
  logic       btn;
  logic       clr;
  logic       A, B, C;
  logic       code_valid, commit_pulse, err_pulse;

  function_code_encoder #(.DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn          (btn),
    .clr          (clr),
    .A            (A),
    .B            (B),
    .C            (C),
    .code_valid   (code_valid),
    .commit_pulse (commit_pulse),
    .err_pulse    (err_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] code;
    logic       valid;
    logic       cp;
    logic       ep;
    int         at;
    string      name;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Raw btn driven before edge k reaches the FSM at k+2, commits at k+5
  // and the outputs appear after edge k+6.
  task automatic push(input string name, input logic [2:0] code, input logic ok);
    exp_t e;
    e.code  = code;
    e.valid = ok;
    e.cp    = ok;
    e.ep    = ~ok;
    e.at    = cyc + 7;
    e.name  = name;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [6:0] s, input int hold, input string name,
                       input logic [2:0] code, input logic ok);
    @(negedge clk);
    sw  = s;
    btn = 1'b1;
    push(name, code, ok);
    tick(hold);
    btn = 1'b0;
    tick(DEB + 6);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (commit_pulse || err_pulse) begin
          if (commit_pulse && err_pulse)
            check("strobe_exclusive", 32'({commit_pulse, err_pulse}), 32'b10);
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_strobe: got commit=%0b err=%0b code=%0b%0b%0b, expected no strobe (cycle %0d)",
                     commit_pulse, err_pulse, A, B, C, cyc);
          end else begin
            e = q.pop_front();
            check({e.name, "_out"}, 32'({A, B, C, code_valid, commit_pulse, err_pulse}),
                  32'({e.code, e.valid, e.cp, e.ep}));
            check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
          end
        end else if (q.size() != 0 && cyc > q[0].at) begin
          e = q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL %s_missing: got no strobe, expected one at cycle %0d", e.name, e.at);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    clr = 1'b0;
    sw  = '0;
    fork
      monitor();
    join_none
    tick(3);
    check("reset_outputs", 32'({A, B, C, code_valid, commit_pulse, err_pulse}), 32'd0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    tick(2);

    // clean press held 10 cycles: one commit of function 2
    press(7'b0000010, 10, "clean", 3'b010, 1'b1);
    check("clean_hold", 32'({A, B, C, code_valid}), 32'b0101);

    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    check("clr_after_clean", 32'({A, B, C, code_valid}), 32'd0);

    // bounce: 3 high, 1 low, 3 high never reaches DEB consecutive samples
    @(negedge clk);
    sw  = 7'b0000100;
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(1);
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(DEB + 6);
    check("bounce_quiet", 32'({A, B, C, code_valid}), 32'd0);

    press(7'b0000100, 4, "hold4", 3'b011, 1'b1);

    press(7'b0000011, 6, "two_sw", 3'b000, 1'b0);
    check("two_sw_hold", 32'({A, B, C, code_valid}), 32'd0);
    press(7'b0000000, 6, "zero_sw", 3'b000, 1'b0);

    press(7'b1000000, 6, "sw7", 3'b111, 1'b1);
    press(7'b0000001, 6, "sw1", 3'b001, 1'b1);

    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    check("clr_after_sw1", 32'({A, B, C, code_valid}), 32'd0);
    check("clr_state", 32'(dut.state), 32'(ST_IDLE));

    // clr presented while the FSM is in COMMIT: the commit wins
    @(negedge clk);
    sw  = 7'b0000010;
    btn = 1'b1;
    push("prio", 3'b010, 1'b1);
    tick(4);
    btn = 1'b0;
    tick(2);
    check("prio_in_commit", 32'(dut.state), 32'(ST_COMMIT));
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(DEB + 6);
    check("prio_hold", 32'({A, B, C, code_valid}), 32'b0101);

    // reset during DEBOUNCE with cnt=2 abandons the press
    @(negedge clk);
    sw  = 7'b0000100;
    btn = 1'b1;
    tick(4);
    check("rst_mid_cnt", 32'(dut.cnt), 32'd2);
    rst = 1'b1;
    btn = 1'b0;
    tick(1);
    rst = 1'b0;
    check("rst_mid_outputs", 32'({A, B, C, code_valid, commit_pulse, err_pulse}), 32'd0);
    check("rst_mid_state", 32'(dut.state), 32'(ST_IDLE));
    tick(DEB + 10);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/function_code_encoder.md
Name: function_code_encoder

Overview:
- Interface-side producer of the 3-bit function code (A, B, C) that the opposite interface's display path validates and shows.
- Takes one user's function switches and a raw confirm button, debounces the button, and encodes the one-hot switch selection into a binary code (function n -> n).
- Holds the committed code with a valid level and one-cycle commit/error strobes.
- Code 010 (function 2) is the only code the display path accepts; all other codes are still produced faithfully.

Parameters:
- DEB_CYCLES, 16, consecutive stable samples required to accept a button press or a release. Legal range >= 2. Board builds override it, e.g. 500000.
- CNT_W, $clog2(DEB_CYCLES)+1, localparam; width of the debounce counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  7  function switches; sw[n-1] selects function n (1..7). Treated as static; not synchronised internally.
- btn  input  1  raw confirm button, active-high, asynchronous/bouncy; double-flop synchronised inside.
- clr  input  1  synchronous request to drop the held code (operation finished).
- A  output  1  code MSB.
- B  output  1  code middle bit.
- C  output  1  code LSB.
- code_valid  output  1  level: held code is a legal committed selection.
- commit_pulse  output  1  one-cycle strobe: legal code committed.
- err_pulse  output  1  one-cycle strobe: commit attempted with zero or multiple switches set.

Behaviour:
- Reset: state=IDLE, counter=0, synchroniser flops=0, A=B=C=0, code_valid=0, commit_pulse=0, err_pulse=0.
  - Reset asserted mid-debounce or mid-release abandons the press with no strobe.
- Synchroniser:
  - btn_s is btn delayed by two flops.
  - All FSM references to btn mean btn_s.
- FSM states: IDLE, DEBOUNCE, COMMIT, RELEASE.
- IDLE:
  - btn_s=1 -> DEBOUNCE, cnt=1.
- DEBOUNCE:
  - btn_s=0 -> IDLE, cnt=0.
  - btn_s=1 and cnt==DEB_CYCLES-1 -> COMMIT.
  - Otherwise cnt++.
  - The press is accepted after DEB_CYCLES consecutive high samples.
- COMMIT (exactly one cycle): sample sw.
  - Exactly one bit set at index k: {A,B,C}=k+1, code_valid=1, commit_pulse=1.
  - Zero or more than one bit set: {A,B,C}=000, code_valid=0, err_pulse=1.
  - These outputs are registered and visible the cycle after the state is COMMIT. Next state is RELEASE, cnt=0.
- RELEASE:
  - btn_s=0: cnt++. When cnt==DEB_CYCLES-1 -> IDLE, cnt=0.
  - btn_s=1: cnt=0, remain in RELEASE.
  - A held button never generates a second commit.
- Strobes: commit_pulse and err_pulse are high for exactly one cycle and are never high together.
- Latency: the first btn_s high sample at edge e0 gives outputs updated at edge e0+DEB_CYCLES+1. Add 2 cycles from raw btn.
- clr:
  - At the next edge sets {A,B,C}=000 and code_valid=0.
  - Does not change FSM state.
  - clr in the same cycle as the COMMIT update: the commit wins and clr is ignored.
- A, B and C change only on a COMMIT update, clr, or rst; they hold otherwise.
- A switch change during DEBOUNCE or RELEASE has no effect. Only the COMMIT-cycle sample matters.

Decomposition:
- Shared package/header holds:
  - the FSM state encoding (2 bits: IDLE=0, DEBOUNCE=1, COMMIT=2, RELEASE=3);
  - the constant FUNC_CODE_DISPLAYABLE=3'b010, shared with the display-side path.
- One natural sub-module: onehot_to_code (7-bit one-hot to 3-bit code plus legal flag), purely combinational and instantiated once.

Test Plan (DEB_CYCLES=4):
- Clean press: sw=7'b0000010, btn held high for 10 cycles -> {A,B,C}=010, code_valid=1, commit_pulse high for exactly 1 cycle, 4+1 cycles after the first btn_s high. No second pulse while held.
- Bounce reject: btn pulses high 3 cycles, low 1, high 3, then low; sw=0000100 -> no commit_pulse, outputs stay 000/0. Then a 4-cycle hold -> code 011.
- Illegal selection: sw=0000011, valid press -> err_pulse for 1 cycle, {A,B,C}=000, code_valid=0. With sw=0 -> same response.
- Re-commit and clear:
  - Commit sw=1000000 -> 111, valid.
  - Release 4 cycles, commit sw=0000001 -> 001.
  - Assert clr for 1 cycle -> 000, valid=0, state unaffected.
- Priority and reset: clr asserted in the COMMIT cycle with sw=0000010 -> outputs 010, valid=1. Assert rst during DEBOUNCE (cnt=2) -> all outputs 0, state IDLE, no strobe after release.
